// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and default sizing for the hazard sequencer
package pipe_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_LU_STALL = 3'd2,
    ST_BR_FLUSH = 3'd3,
    ST_MEM_WAIT = 3'd4
  } state_e;
  localparam int DEF_INIT_CYCLES  = 4;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_CNT_W        = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: enabled up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  assign o_q = r_q;
  // count enabled cycles, holding once every bit is set
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= '0;
    else if (i_en && r_q != '1) r_q <= r_q + 1'b1;
endmodule

// File: rtl/pipe_hazard_sequencer.sv
// pipe_hazard_sequencer: Moore FSM arbitrating init, load-use, branch flush and memory-wait pipeline controls
module pipe_hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             init,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush,
  output logic             freeze,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] event_cnt
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);
  logic [2:0]    r_state;
  logic [IW-1:0] r_init_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic [2:0]    w_next_state;
  logic [IW-1:0] w_init_next;
  logic [FW-1:0] w_flush_next;
  logic [FW-1:0] w_flush_dec;
  logic          w_mem_stall;
  logic          w_event_en;
  assign w_mem_stall = dmem_req & ~dmem_ready;
  assign w_flush_dec = (r_flush_cnt > FW'(1)) ? r_flush_cnt - 1'b1 : '0;
  assign state       = r_state;
  // state and inline down/up counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_init_cnt  <= w_init_next;
      r_flush_cnt <= w_flush_next;
    end
  // next-state arbitration: memory wait beats branch beats load-use
  always_comb begin
    w_next_state = ST_RUN;
    w_init_next  = r_init_cnt;
    w_flush_next = '0;
    case (r_state)
      ST_INIT: begin
        w_init_next  = r_init_cnt + 1'b1;
        w_next_state = (r_init_cnt == INIT_LAST) ? ST_RUN : ST_INIT;
      end
      ST_RUN, ST_LU_STALL: begin
        w_next_state = w_mem_stall ? ST_MEM_WAIT :
                       br_taken ? ST_BR_FLUSH :
                       (load_use && r_state == ST_RUN) ? ST_LU_STALL : ST_RUN;
        w_flush_next = (!w_mem_stall && br_taken) ? FLUSH_LOAD : '0;
      end
      ST_BR_FLUSH: begin
        w_next_state = w_mem_stall ? ST_MEM_WAIT :
                       (br_taken || w_flush_dec != '0) ? ST_BR_FLUSH : ST_RUN;
        w_flush_next = (!w_mem_stall && br_taken) ? FLUSH_LOAD : w_flush_dec;
      end
      ST_MEM_WAIT: begin
        w_next_state = !dmem_ready ? ST_MEM_WAIT :
                       (r_flush_cnt != '0) ? ST_BR_FLUSH : ST_RUN;
        w_flush_next = r_flush_cnt;
      end
      default: ;
    endcase
  end
  // Moore output decode from registered state only
  always_comb begin
    init        = r_state == ST_INIT;
    pc_write    = !(r_state == ST_LU_STALL || r_state == ST_MEM_WAIT);
    ifid_write  = !(r_state == ST_LU_STALL || r_state == ST_MEM_WAIT);
    idex_bubble = r_state == ST_LU_STALL || r_state == ST_BR_FLUSH;
    flush       = r_state == ST_BR_FLUSH;
    freeze      = r_state == ST_MEM_WAIT;
  end
  assign w_event_en = (~pc_write | flush) & ~init;
  sat_counter #(.W(CNT_W)) u_event_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_event_en),
    .o_q  (event_cnt)
  );
endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// tb_pipe_hazard_sequencer: directed vectors with hand-computed expectations
module tb_pipe_hazard_sequencer;
  logic       clk = 0;
  logic       rst = 1;
  logic       load_use = 0, br_taken = 0, dmem_req = 0, dmem_ready = 0;
  logic       init, pc_write, ifid_write, idex_bubble, flush, freeze;
  logic [2:0] state;
  logic [3:0] event_cnt;
  int         n_checks = 0;
  int         n_errors = 0;
  pipe_hazard_sequencer #(.INIT_CYCLES(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_use    (load_use),
    .br_taken    (br_taken),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .init        (init),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_bubble (idex_bubble),
    .flush       (flush),
    .freeze      (freeze),
    .state       (state),
    .event_cnt   (event_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_init"}, init, 1);
    check({tag, "_pc"}, pc_write, 1);
    check({tag, "_ifid"}, ifid_write, 1);
    check({tag, "_bub"}, idex_bubble, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_freeze"}, freeze, 0);
    check({tag, "_evt"}, event_cnt, 0);
  endtask
  task automatic init_window(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_init_hi"}, init, 1);
      tick();
    end
    check({tag, "_init_lo"}, init, 0);
    check({tag, "_run"}, state, 1);
    check({tag, "_run_pc"}, pc_write, 1);
    check({tag, "_run_evt"}, event_cnt, 0);
  endtask
  initial begin
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 0;
    init_window("boot");
    load_use = 1;
    tick();
    load_use = 0;
    check("lu_state", state, 2);
    check("lu_pc", pc_write, 0);
    check("lu_ifid", ifid_write, 0);
    check("lu_bub", idex_bubble, 1);
    tick();
    check("lu_back", state, 1);
    check("lu_evt", event_cnt, 1);
    load_use = 1;
    br_taken = 1;
    tick();
    load_use = 0;
    br_taken = 0;
    check("br1_state", state, 3);
    check("br1_flush", flush, 1);
    check("br1_bub", idex_bubble, 1);
    check("br1_pc", pc_write, 1);
    tick();
    check("br2_flush", flush, 1);
    tick();
    check("br_back", state, 1);
    check("br_noflush", flush, 0);
    check("br_evt", event_cnt, 3);
    dmem_req = 1;
    dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mw_state", state, 4);
      check("mw_freeze", freeze, 1);
      check("mw_pc", pc_write, 0);
    end
    dmem_req = 0;
    dmem_ready = 1;
    tick();
    check("mw_back", state, 1);
    check("mw_unfreeze", freeze, 0);
    check("mw_evt", event_cnt, 6);
    dmem_req = 1;
    dmem_ready = 1;
    tick();
    dmem_req = 0;
    dmem_ready = 0;
    check("zw_state", state, 1);
    check("zw_freeze", freeze, 0);
    check("zw_evt", event_cnt, 6);
    br_taken = 1;
    tick();
    br_taken = 0;
    check("bm_flush1", flush, 1);
    dmem_req = 1;
    tick();
    dmem_req = 0;
    check("bm_wait", state, 4);
    check("bm_noflush", flush, 0);
    tick();
    check("bm_wait2", state, 4);
    dmem_ready = 1;
    tick();
    dmem_ready = 0;
    check("bm_resume", state, 3);
    check("bm_flush2", flush, 1);
    tick();
    check("bm_done", state, 1);
    check("bm_done_flush", flush, 0);
    check("bm_evt", event_cnt, 10);
    dmem_req = 1;
    tick();
    dmem_req = 0;
    check("rw_wait", freeze, 1);
    #2 rst = 1;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 0;
    init_window("reboot");
    dmem_req = 1;
    tick();
    dmem_req = 0;
    repeat (19) tick();
    check("sat_wait", state, 4);
    dmem_ready = 1;
    tick();
    dmem_ready = 0;
    check("sat_back", state, 1);
    check("sat_evt", event_cnt, 15);
    load_use = 1;
    tick();
    load_use = 0;
    tick();
    check("sat_hold", event_cnt, 15);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
